sg_stream_filter: RTL
=====================

// Module: sg_stream_filter
// PURPOSE
//  Synthesizable streaming Savitzky-Golay smoother: fixed-point FIR with SG coefficients, framed valid/ready in/out.
//  Replaces the offline per-window polynomial fit. Frame of N samples in -> exactly N smoothed samples out.
//  Edges replicate the first/last sample (x[clamp(n,0,N-1)]). Sits between sample capture and results writer.
// PARAMETERS
//  DATA_W     16               signed sample width, in and out
//  WIN        7                window length, odd, 3..15; HALF = WIN/2
//  COEF_W     16               signed coefficient width
//  COEF_FRAC  14               coefficient fraction bits (Q2.14 default)
//  COEFS      sg_pkg::SG_C7    WIN-entry coefficient array, index 0 = tap x[k-HALF]
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, asynchronous, active-high
//  s_valid     in   1        input sample valid
//  s_ready     out  1        filter accepts sample
//  s_data      in   DATA_W   input sample, signed
//  s_last      in   1        final sample of frame
//  m_valid     out  1        output sample valid
//  m_ready     in   1        downstream accepts
//  m_data      out  DATA_W   smoothed sample, signed
//  m_last      out  1        final output of frame
//  coef_wr_en  in   1        [SG_COEF_LOAD_EN] coefficient write strobe
//  coef_addr   in   4        [SG_COEF_LOAD_EN] tap index 0..WIN-1
//  coef_data   in   COEF_W   [SG_COEF_LOAD_EN] coefficient value
// BEHAVIOUR
//  - Reset: s_ready=1, m_valid=0, m_data=0, m_last=0, window/acc/counters cleared, FSM=IDLE. Applies mid-frame; partial frame dropped.
//  - Transfers occur on s_valid&s_ready / m_valid&m_ready at posedge clk.
//  - Output k: y[k] = sat(( sum_j COEF[j]*x[clamp(k+j-HALF)] + 2^(COEF_FRAC-1) ) >>> COEF_FRAC).
//    Accumulator DATA_W+COEF_W+$clog2(WIN) bits signed; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  - FSM states:
//    IDLE:   s_ready=1. Accept x0 -> window slots 0..HALF := x0, seen=1. -> PAD if s_last, else ACCEPT.
//    ACCEPT: s_ready=1. Accept sample -> shift in at slot WIN-1. -> MAC if window complete (right edge = x[out_cnt+HALF]),
//            else stay ACCEPT (s_last with window incomplete -> PAD).
//    PAD:    s_ready=0, 1 cycle: shift in last sample again (right-edge replication). -> MAC if complete, else PAD.
//    MAC:    s_ready=0, WIN cycles, one tap per cycle, tap 0 first. -> OUT.
//    OUT:    m_valid=1, m_data/m_last stable until m_ready. On handshake out_cnt++:
//            frame done (out_cnt==N) -> IDLE; last seen -> PAD; else ACCEPT.
//  - m_last=1 exactly with output N-1. Counters track only HALF lookahead and pad count; frame length unbounded.
//  - Throughput: one sample per WIN+2 cycles with m_ready=1. Latency s_valid of x[HALF] -> m_valid of y[0]: WIN+1 cycles.
//  - s_valid while s_ready=0: held by upstream, not sampled. m_ready while m_valid=0: ignored.
//  - N=1: output sum(COEF)*x0 rounded/saturated, m_last=1. N<=HALF handled by clamp/padding, still N outputs.
// CONFIGURATION
//  - SG_COEF_LOAD_EN defined: coefficient register file initialised from COEFS at reset; coef_wr_en writes
//    coef_data to tap coef_addr only in IDLE; writes in other states or coef_addr>=WIN ignored. New values apply from next frame.
//  - Undefined: coef_* ports absent, coefficients are the constant COEFS (no registers).
// STRUCTURE
//  - sg_pkg: SG_C7 = {-1560,2341,4681,5461,4681,2341,-1560} (Q2.14), state enum sg_state_t, sat/round helper function.
//  - One sub-module: sg_mac (sequential multiply-accumulate, round, saturate; start/done handshake to FSM).
//  - Top: window shift register, FSM, counters, optional coef regfile.
// TESTING
//  1. Constant 1000, N=10 -> ten outputs all 1000, m_last on 10th only.
//  2. Ramp x[n]=100n, N=20 -> y[3..16]=100k exactly; y[0]=29 (edge replication, rounding); 20 outputs.
//  3. Constant 32767, N=8 -> all outputs 32767 (saturated); constant -32768 -> all -32768.
//  4. Ramp N=20, m_ready low 20 cycles after y[5] -> m_data/m_valid held, s_ready=0, no sample lost or duplicated.
//  5. Single sample 500 with s_last -> one output 500, m_last=1, FSM back in IDLE (s_ready=1).
//  6. rst pulse during MAC of frame A -> m_valid=0, s_ready=1 immediately; following constant-1000 frame outputs all 1000.
//  7. SG_COEF_LOAD_EN: load {0,0,0,16384,0,0,0} in IDLE -> output equals input; write during MAC -> ignored.

Source files
------------

// File: rtl/sg_pkg.sv
// Shared types, default Savitzky-Golay coefficients and the round/saturate helper
// used by the streaming SG smoother.
package sg_pkg;

  // 7-tap quadratic SG smoothing kernel in Q2.14, index 0 = oldest tap
  localparam logic signed [15:0] SG_C7 [7] = '{
    -16'sd1560, 16'sd2341, 16'sd4681, 16'sd5461, 16'sd4681, 16'sd2341, -16'sd1560
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_PAD,
    ST_MAC,
    ST_OUT
  } sg_state_t;

  // Round half-up at the binary point, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] sg_round_sat(input logic signed [63:0] acc,
                                                      input int frac,
                                                      input int dw);
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (dw - 1));
    if (rounded > max_v) return max_v;
    if (rounded < min_v) return min_v;
    return rounded;
  endfunction

endpackage

// File: rtl/sg_mac.sv
// Sequential multiply-accumulate: one tap per cycle after i_start, tap 0 first;
// the final sum is rounded, saturated and held in o_result until the next start.
module sg_mac
  import sg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int WIN       = 7,
  parameter int TAP_W     = $clog2(WIN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_c,
  output logic [TAP_W-1:0]         o_tap,
  output logic                     o_done,
  output logic signed [DATA_W-1:0] o_result
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(WIN);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(WIN - 1);

  logic                     r_busy;
  logic [TAP_W-1:0]         r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_result;
  logic signed [ACC_W-1:0]  w_acc_next;

  assign w_acc_next = r_acc + ACC_W'(i_x) * ACC_W'(i_c);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_tap    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_tap  <= '0;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      if (r_tap == LAST_TAP) begin
        r_busy   <= 1'b0;
        r_tap    <= '0;
        r_result <= DATA_W'(sg_round_sat(64'(w_acc_next), COEF_FRAC, DATA_W));
      end else begin
        r_tap <= r_tap + 1'b1;
      end
    end
  end

  assign o_tap    = r_tap;
  assign o_done   = r_busy && (r_tap == LAST_TAP);
  assign o_result = r_result;

endmodule

// File: rtl/sg_stream_filter.sv
// Framed streaming Savitzky-Golay smoother with edge replication.
// Define SG_COEF_LOAD_EN to add a run-time writable coefficient register file.
module sg_stream_filter
  import sg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int WIN       = 7,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter logic signed [COEF_W-1:0] COEFS [WIN] = SG_C7
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef SG_COEF_LOAD_EN
  input  logic                     coef_wr_en,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
`endif
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_last
);

  localparam int HALF  = WIN / 2;
  localparam int TAP_W = $clog2(WIN);
  localparam int CNT_W = $clog2(WIN);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);

  sg_state_t                r_state, w_next;
  logic signed [DATA_W-1:0] r_win [WIN];
  logic [CNT_W-1:0]         r_lead, r_pad_cnt, w_lead_inc;
  logic                     r_last_seen;
  logic                     w_start, w_done, w_frame_end;
  logic [TAP_W-1:0]         w_tap;
  logic signed [COEF_W-1:0] w_coef [WIN];
  logic signed [DATA_W-1:0] w_result;

  // r_lead = samples held beyond the output centre; r_pad_cnt = replications after s_last
  assign w_lead_inc  = r_lead + 1'b1;
  assign w_frame_end = r_last_seen && (r_pad_cnt == HALF_C);
  assign w_start     = (r_state != ST_MAC) && (w_next == ST_MAC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (s_valid) w_next = s_last ? ST_PAD : ST_ACCEPT;
      ST_ACCEPT: if (s_valid) begin
                   if (w_lead_inc == HALF_C) w_next = ST_MAC;
                   else if (s_last)          w_next = ST_PAD;
                 end
      ST_PAD:    if (w_lead_inc == HALF_C) w_next = ST_MAC;
      ST_MAC:    if (w_done) w_next = ST_OUT;
      ST_OUT:    if (m_ready) w_next = w_frame_end ? ST_IDLE
                                     : (r_last_seen ? ST_PAD : ST_ACCEPT);
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (r_state == ST_IDLE) || (r_state == ST_ACCEPT);
    m_valid = (r_state == ST_OUT);
    m_last  = (r_state == ST_OUT) && w_frame_end;
  end

  assign m_data = w_result;

  // NOTE: the window array is reset too, so a frame cut short by rst leaves no stale samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
      r_lead      <= '0;
      r_pad_cnt   <= '0;
      r_last_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (s_valid) begin
          // Filling every slot with x0 replicates the left edge once HALF samples shift in.
          for (int i = 0; i < WIN; i++) r_win[i] <= s_data;
          r_lead      <= '0;
          r_pad_cnt   <= '0;
          r_last_seen <= s_last;
        end
        ST_ACCEPT: if (s_valid) begin
          for (int i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
          r_win[WIN-1] <= s_data;
          r_lead       <= w_lead_inc;
          r_last_seen  <= s_last;
        end
        ST_PAD: begin
          for (int i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
          r_lead    <= w_lead_inc;
          r_pad_cnt <= r_pad_cnt + 1'b1;
        end
        ST_OUT: if (m_ready) r_lead <= r_lead - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SG_COEF_LOAD_EN
  localparam logic [3:0] WIN_A = 4'(WIN);
  logic signed [COEF_W-1:0] r_coef [WIN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) r_coef[i] <= COEFS[i];
    end else if (coef_wr_en && (r_state == ST_IDLE) && (coef_addr < WIN_A)) begin
      r_coef[coef_addr[TAP_W-1:0]] <= coef_data;
    end
  end

  always_comb begin
    for (int i = 0; i < WIN; i++) w_coef[i] = r_coef[i];
  end
`else
  always_comb begin
    for (int i = 0; i < WIN; i++) w_coef[i] = COEFS[i];
  end
`endif

  sg_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .COEF_FRAC(COEF_FRAC),
    .WIN      (WIN),
    .TAP_W    (TAP_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_x     (r_win[w_tap]),
    .i_c     (w_coef[w_tap]),
    .o_tap   (w_tap),
    .o_done  (w_done),
    .o_result(w_result)
  );

endmodule
